// File: rtl/burst_mem_responder.sv
// burst_mem_responder
//   Memory-side responder for the 4-beat x 64-bit line burst protocol.
//   A request is accepted in IDLE. After LATENCY wait cycles, four beats are
//   returned (read) or absorbed (write), with resp_o high on each beat. One
//   COOL cycle follows, then the block is back in IDLE.
//
//   Optional feature macro: BURST_MEM_PROTOCOL_CHECK_EN (adds sticky err_o).
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous active-high reset
//   address_i  : byte address; line index = address_i[5 +: log2(LINES)]
//   read_i     : read request, held until the burst completes
//   write_i    : write request, held until the burst completes
//   burst_i    : write beat, sampled while resp_o = 1
//   burst_o    : read beat, 0 whenever resp_o = 0
//   resp_o     : beat strobe, 4 consecutive cycles per burst
//   err_o      : sticky protocol error (only with BURST_MEM_PROTOCOL_CHECK_EN)
//
// state | meaning
// IDLE  | waiting for read_i / write_i; latches direction and line index
// WAIT  | latency down-counter running; request lines ignored
// BURST | beats 0..3, one per cycle, resp_o high
// COOL  | one dead cycle while the initiator drops its request
module burst_mem_responder #(
  parameter int LINES   = 16,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [63:0] burst_i,
  output logic [63:0] burst_o,
  output logic        resp_o
`ifdef BURST_MEM_PROTOCOL_CHECK_EN
  ,
  output logic        err_o
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int WA_W  = IDX_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_COOL} state_t;

  state_t             state_q, state_d;
  logic [3:0]         lat_q, lat_d;
  logic [1:0]         beat_q, beat_d;
  logic               rd_q, rd_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               resp_d;
  logic [63:0]        burst_d;

  // Line array stored as 64-bit words addressed by {line, beat}; not reset.
  logic [63:0]        mem [LINES*4];

  // Address bits above the index alias silently; bits [4:0] are ignored.
  logic               unused_addr;
  assign unused_addr = ^{address_i[31:5+IDX_W], address_i[4:0]};

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    rd_d    = rd_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (read_i || write_i) begin
          rd_d   = read_i;
          idx_d  = address_i[5 +: IDX_W];
          beat_d = 2'd0;
          if (LATENCY == 0) begin
            state_d = S_BURST;
          end else begin
            state_d = S_WAIT;
            lat_d   = 4'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        if (lat_q == 4'd0) begin
          state_d = S_BURST;
          beat_d  = 2'd0;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      S_BURST: begin
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = S_COOL;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are computed from next-state values so they can be registered
    // and still line up with the beat they describe.
    resp_d  = (state_d == S_BURST);
    burst_d = (resp_d && rd_d) ? mem[{idx_d, beat_d}] : 64'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      lat_q   <= 4'd0;
      beat_q  <= 2'd0;
      rd_q    <= 1'b0;
      idx_q   <= '0;
      resp_o  <= 1'b0;
      burst_o <= 64'd0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      rd_q    <= rd_d;
      idx_q   <= idx_d;
      resp_o  <= resp_d;
      burst_o <= burst_d;
    end
  end

  // Each write beat commits on its own; an async reset leaves IDLE at once,
  // so beats after the reset are never written.
  always_ff @(posedge clk) begin
    if (state_q == S_BURST && !rd_q) begin
      mem[WA_W'({idx_q, beat_q})] <= burst_i;
    end
  end

`ifdef BURST_MEM_PROTOCOL_CHECK_EN
  logic proto_bad;
  assign proto_bad = ((state_q == S_WAIT) || (state_q == S_BURST)) &&
                     (rd_q ? (!read_i || write_i) : (!write_i || read_i));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_o <= 1'b0;
    end else if (proto_bad) begin
      err_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_burst_mem_responder.sv
module tb_burst_mem_responder;

  localparam int LAT = 2;
  localparam int NL  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address_i;
  logic        read_i;
  logic        write_i;
  logic [63:0] burst_i;
  logic [63:0] burst_o;
  logic        resp_o;
`ifdef BURST_MEM_PROTOCOL_CHECK_EN
  logic        err_o;
`endif

  burst_mem_responder #(.LINES(NL), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .resp_o    (resp_o)
`ifdef BURST_MEM_PROTOCOL_CHECK_EN
    ,
    .err_o     (err_o)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    bit          chk;
    logic [63:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] mdl  [NL][4];
  bit          mval [NL][4];
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, req);
  endtask

  // Monitor: pops one expectation per presented beat.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (resp_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          if (e.chk) check("read_beat", burst_o, e.data);
        end
      end else begin
        check("burst_o_idle", burst_o, 64'd0);
      end
    end
  end

  task automatic do_reset();
    reset   = 1'b1;
    read_i  = 1'b0;
    write_i = 1'b0;
    burst_i = 64'd0;
    #1;
    check("reset_resp", resp_o, 64'd0);
    check("reset_burst", burst_o, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic go_idle(input int n);
    read_i  = 1'b0;
    write_i = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge (start of cycle 0); returns at the negedge of cycle
  // LAT+6 with the request still held, so a following call is back-to-back.
  task automatic run_burst(input logic [31:0] addr, input bit rd, input bit wr,
                           input logic [255:0] wline, input int abort_beat,
                           input int drop_beat);
    int li;
    int k;
    bit exp_resp;
    li = int'((addr >> 5) % NL);
    for (int b = 0; b < 4; b++) begin
      if (rd) exp_q.push_back('{chk: mval[li][b], data: mdl[li][b]});
      else    exp_q.push_back('{chk: 1'b0, data: 64'd0});
    end
    address_i = addr;
    read_i    = rd;
    write_i   = wr;
    for (int c = 0; c <= LAT + 5; c++) begin
      if (c > 0) @(negedge clk);
      exp_resp = (c >= LAT + 1) && (c <= LAT + 4);
      k = c - LAT - 1;
      check($sformatf("resp_cycle%0d", c), resp_o, exp_resp);
`ifdef BURST_MEM_PROTOCOL_CHECK_EN
      if (drop_beat >= 0 && k == drop_beat + 1) check("err_set", err_o, 64'd1);
`endif
      if (exp_resp && k == abort_beat) begin
        #1 reset = 1'b1;
        #1;
        check("resp_at_reset", resp_o, 64'd0);
        check("burst_at_reset", burst_o, 64'd0);
        exp_q.delete();
        @(negedge clk);
        reset   = 1'b0;
        read_i  = 1'b0;
        write_i = 1'b0;
        burst_i = 64'd0;
        return;
      end
      if (exp_resp) begin
        burst_i = wline[64*k +: 64];
        if (!rd) begin
          mdl[li][k]  = burst_i;
          mval[li][k] = 1'b1;
        end
      end else begin
        burst_i = {$urandom, $urandom};
      end
      if (drop_beat >= 0) read_i = (k == drop_beat) ? 1'b0 : rd;
    end
    @(negedge clk);
  endtask

  logic [255:0] line_a;
  logic [255:0] zeros;
  logic [255:0] ones;
  logic [255:0] rnd;

  initial begin
    reset     = 1'b1;
    address_i = 32'd0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    burst_i   = 64'd0;
    mon_en    = 1'b1;
    line_a = {64'h4444444444444444, 64'h3333333333333333,
              64'h2222222222222222, 64'h1111111111111111};
    zeros  = '0;
    ones   = '1;

    do_reset();

    // Write then read, back-to-back, then a held read re-accepted.
    run_burst(32'h40, 1'b0, 1'b1, line_a, -1, -1);
    run_burst(32'h40, 1'b1, 1'b0, '0, -1, -1);
    run_burst(32'h40, 1'b1, 1'b0, '0, -1, -1);
    go_idle(2);

    // Read priority: both requests, burst_i garbage must not land.
    rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_burst(32'h40, 1'b1, 1'b1, rnd, -1, -1);
    run_burst(32'h40, 1'b1, 1'b0, '0, -1, -1);
    go_idle(1);

    // Low bits ignored, high bits alias.
    run_burst(32'h5F, 1'b1, 1'b0, '0, -1, -1);
    run_burst(32'h240, 1'b1, 1'b0, '0, -1, -1);
    go_idle(1);

    // Reset in the middle of a write.
    run_burst(32'h80, 1'b0, 1'b1, zeros, -1, -1);
    go_idle(1);
    run_burst(32'h80, 1'b0, 1'b1, ones, 2, -1);
    go_idle(1);
    run_burst(32'h80, 1'b1, 1'b0, '0, -1, -1);
    go_idle(1);

`ifdef BURST_MEM_PROTOCOL_CHECK_EN
    do_reset();
    check("err_after_reset", err_o, 64'd0);
    run_burst(32'h40, 1'b1, 1'b0, '0, -1, -1);
    go_idle(1);
    check("err_clean", err_o, 64'd0);
    run_burst(32'h40, 1'b1, 1'b0, '0, -1, 1);
    go_idle(1);
    run_burst(32'h80, 1'b1, 1'b0, '0, -1, -1);
    go_idle(1);
    check("err_sticky", err_o, 64'd1);
    do_reset();
    check("err_cleared", err_o, 64'd0);
`endif

    // Randomized traffic against the line model.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      int          sel;
      a   = ($urandom_range(0, 5) << 5) | $urandom_range(0, 31) |
            ($urandom_range(0, 3) << (5 + $clog2(NL)));
      sel = $urandom_range(0, 3);
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_burst(a, sel != 3, sel == 0 || sel == 3, rnd, -1, -1);
      if ($urandom_range(0, 1) == 1) go_idle($urandom_range(1, 3));
    end
    go_idle(4);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
